// File: rtl/lsu_pkg.sv
// Shared types and lane-steering helpers for the LSU-to-Wishbone bridge.
// Sizes, FSM states, and byte-select/replication/extraction functions live here.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } lsu_size_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_BUS   = 2'b01,
      ST_RDATA = 2'b10,
      ST_RESP  = 2'b11
   } lsu_state_e;

   // Illegal size or a half/word that does not sit on its natural boundary.
   function automatic logic lsu_bad(input lsu_size_e sz, input logic [1:0] off);
      logic bad;
      case (sz)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = off[0];
         SZ_WORD: bad = (off != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [3:0] lsu_sel(input lsu_size_e sz, input logic [1:0] off);
      logic [3:0] sel;
      case (sz)
         SZ_BYTE: sel = 4'b0001 << off;
         SZ_HALF: sel = 4'b0011 << {off[1], 1'b0};
         SZ_WORD: sel = 4'b1111;
         default: sel = 4'b0000;
      endcase
      return sel;
   endfunction

   function automatic logic [31:0] lsu_rep(input lsu_size_e sz, input logic [31:0] wd);
      logic [31:0] r;
      case (sz)
         SZ_BYTE: r = {4{wd[7:0]}};
         SZ_HALF: r = {2{wd[15:0]}};
         default: r = wd;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] lsu_extract(input lsu_size_e sz, input logic [1:0] off,
                                               input logic uns, input logic [31:0] rd);
      logic [31:0] s;
      logic [31:0] r;
      s = rd >> {off, 3'b000};
      case (sz)
         SZ_BYTE: r = uns ? {24'h0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
         SZ_HALF: r = uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
         default: r = s;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: Wishbone selects, store replication,
// and load extraction with sign/zero extension.
module lsu_align
   import lsu_pkg::*;
(
   input  lsu_size_e   size,
   input  logic [1:0]  off,
   input  logic        uns,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  sel,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext
);

   always_comb begin
      sel       = lsu_sel(size, off);
      wdata_rep = lsu_rep(size, wdata);
      rdata_ext = lsu_extract(size, off, uns, rdata);
   end

endmodule

// File: rtl/lsu_wb_bridge.sv
// Single-outstanding LSU request to Wishbone classic bridge.
// Optional bus watchdog enabled by defining LSU_TIMEOUT_EN (limit = TIMEOUT cycles).
module lsu_wb_bridge
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        cyc_o,
   output logic        stb_o,
   output logic        we_o,
   output logic [31:0] adr_o,
   output logic [3:0]  sel_o,
   output logic [31:0] dat_o,
   input  logic [31:0] dat_i,
   input  logic        ack_i
);

   lsu_state_e  state_q, state_d;
   logic        we_q, uns_q, err_q;
   logic [31:0] addr_q, wdata_q, rdata_q;
   lsu_size_e   size_q;
   logic        accept, req_bad, in_bus, to_hit;
   logic [3:0]  sel_w;
   logic [31:0] wrep_w, rext_w;

   assign accept  = req_valid_i && (state_q == ST_IDLE);
   assign req_bad = lsu_bad(lsu_size_e'(req_size_i), req_addr_i[1:0]);
   assign in_bus  = (state_q == ST_BUS);

`ifdef LSU_TIMEOUT_EN
   logic [31:0] cnt_q;

   assign to_hit = in_bus && !ack_i && (cnt_q == 32'(TIMEOUT - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i || !in_bus) cnt_q <= '0;
      else                  cnt_q <= cnt_q + 32'd1;
   end
`else
   // Watchdog absent: the bridge waits on the slave forever.
   logic [31:0] unused_timeout;
   assign unused_timeout = 32'(TIMEOUT);
   assign to_hit         = 1'b0;
`endif

   lsu_align u_align (
      .size      (size_q),
      .off       (addr_q[1:0]),
      .uns       (uns_q),
      .wdata     (wdata_q),
      .rdata     (dat_i),
      .sel       (sel_w),
      .wdata_rep (wrep_w),
      .rdata_ext (rext_w)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (req_valid_i) state_d = req_bad ? ST_RESP : ST_BUS;
         ST_BUS: begin
            if (ack_i)       state_d = we_q ? ST_RESP : ST_RDATA;
            else if (to_hit) state_d = ST_RESP;
         end
         ST_RDATA: state_d = ST_RESP;
         default:  state_d = ST_IDLE;
      endcase
   end

   // rdata_q is only written on the way into RESP so it stays put between responses.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= SZ_BYTE;
         rdata_q <= '0;
      end else begin
         if (accept) begin
            we_q    <= req_we_i;
            uns_q   <= req_unsigned_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            size_q  <= lsu_size_e'(req_size_i);
            err_q   <= req_bad;
            if (req_bad) rdata_q <= '0;
         end
         if (in_bus && ack_i && we_q) rdata_q <= '0;
         if (in_bus && !ack_i && to_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
         end
         if (state_q == ST_RDATA) rdata_q <= rext_w;
      end
   end

   assign req_ready_o = (state_q == ST_IDLE);
   assign rsp_valid_o = (state_q == ST_RESP);
   assign rsp_err_o   = (state_q == ST_RESP) && err_q;
   assign rsp_rdata_o = rdata_q;
   assign cyc_o       = in_bus;
   assign stb_o       = in_bus;
   assign we_o        = in_bus && we_q;
   assign adr_o       = in_bus ? {addr_q[31:2], 2'b00} : '0;
   assign sel_o       = in_bus ? sel_w : '0;
   assign dat_o       = (in_bus && we_q) ? wrep_w : '0;

endmodule

// File: tb/tb_lsu_wb_bridge.sv
// Directed bench for lsu_wb_bridge; watchdog scenario switches on LSU_TIMEOUT_EN.
module tb_lsu_wb_bridge;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
   logic [31:0] req_addr_i, req_wdata_i;
   logic [1:0]  req_size_i;
   logic        rsp_valid_o, rsp_err_o;
   logic [31:0] rsp_rdata_o;
   logic        cyc_o, stb_o, we_o, ack_i;
   logic [31:0] adr_o, dat_o, dat_i;
   logic [3:0]  sel_o;

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   lsu_wb_bridge #(.TIMEOUT(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_size_i(req_size_i),
      .req_unsigned_i(req_unsigned_i), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
      .rsp_err_o(rsp_err_o), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
      .sel_o(sel_o), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] sz, input logic uns);
      req_valid_i = 1'b1; req_we_i = we; req_addr_i = a;
      req_wdata_i = wd; req_size_i = sz; req_unsigned_i = uns;
   endtask

   initial begin
      rst_i = 1'b1; req_valid_i = 0; req_we_i = 0; req_addr_i = 0; req_wdata_i = 0;
      req_size_i = 0; req_unsigned_i = 0; ack_i = 0; dat_i = 0;
      tick(); tick();
      chk("rst_ready", {31'b0, req_ready_o}, 32'd1);
      chk("rst_outs", {cyc_o, stb_o, we_o, rsp_valid_o, rsp_err_o, sel_o}, 32'd0);
      chk("rst_buses", adr_o | dat_o | rsp_rdata_o, 32'd0);
      rst_i = 1'b0;
      tick();

      // Store byte 0xA5 to 0x102, zero-wait slave.
      req(1'b1, 32'h0000_0102, 32'h0000_00A5, 2'b00, 1'b0);
      chk("sb_ready_T", {31'b0, req_ready_o}, 32'd1);
      tick(); req_valid_i = 0; ack_i = 1;
      chk("sb_cyc", {30'b0, cyc_o, stb_o}, 32'd3);
      chk("sb_we", {31'b0, we_o}, 32'd1);
      chk("sb_adr", adr_o, 32'h0000_0100);
      chk("sb_sel", {28'b0, sel_o}, 32'h4);
      chk("sb_dat", dat_o, 32'hA5A5_A5A5);
      tick(); ack_i = 0;
      chk("sb_valid_T2", {30'b0, rsp_valid_o, rsp_err_o}, 32'd2);
      chk("sb_rdata", rsp_rdata_o, 32'd0);
      chk("sb_cyc_drop", {31'b0, cyc_o}, 32'd0);
      tick();
      chk("sb_done", {30'b0, rsp_valid_o, req_ready_o}, 32'd1);

      // Load half signed from 0x202, word 0x8001_1234.
      req(1'b0, 32'h0000_0202, 32'h0, 2'b01, 1'b0);
      tick(); req_valid_i = 0; ack_i = 1;
      chk("lh_sel", {28'b0, sel_o}, 32'hC);
      chk("lh_dat", dat_o, 32'd0);
      tick(); ack_i = 0; dat_i = 32'h8001_1234;
      chk("lh_rdata_state", {30'b0, cyc_o, rsp_valid_o}, 32'd0);
      tick(); dat_i = 32'hDEAD_BEEF;
      chk("lh_valid_T3", {30'b0, rsp_valid_o, rsp_err_o}, 32'd2);
      chk("lh_signed", rsp_rdata_o, 32'hFFFF_8001);
      tick();
      chk("lh_hold", rsp_rdata_o, 32'hFFFF_8001);

      // Same, unsigned.
      req(1'b0, 32'h0000_0202, 32'h0, 2'b01, 1'b1);
      tick(); req_valid_i = 0; ack_i = 1;
      tick(); ack_i = 0; dat_i = 32'h8001_1234;
      tick(); dat_i = 32'h0;
      chk("lhu_data", rsp_rdata_o, 32'h0000_8001);
      tick();

      // Misaligned word load: straight to error response.
      req(1'b0, 32'h0000_0101, 32'h0, 2'b10, 1'b0);
      tick(); req_valid_i = 0;
      chk("lw_mis_nocyc", {31'b0, cyc_o}, 32'd0);
      chk("lw_mis_rsp", {30'b0, rsp_valid_o, rsp_err_o}, 32'd3);
      chk("lw_mis_rdata", rsp_rdata_o, 32'd0);
      tick();
      chk("lw_mis_idle", {31'b0, req_ready_o}, 32'd1);

      // Illegal size and odd half address.
      req(1'b1, 32'h0000_0000, 32'h0, 2'b11, 1'b0);
      tick(); req_valid_i = 0;
      chk("ill_size", {29'b0, cyc_o, rsp_valid_o, rsp_err_o}, 32'd3);
      tick();
      req(1'b0, 32'h0000_0003, 32'h0, 2'b01, 1'b0);
      tick(); req_valid_i = 0;
      chk("odd_half", {29'b0, cyc_o, rsp_valid_o, rsp_err_o}, 32'd3);
      tick();

      // Stray ack while idle is ignored.
      ack_i = 1;
      tick(); ack_i = 0;
      chk("stray_ack", {29'b0, cyc_o, rsp_valid_o, req_ready_o}, 32'd1);

      // Store word to 0x300, ack delayed 3 cycles; a second request is ignored meanwhile.
      req(1'b1, 32'h0000_0300, 32'h1234_5678, 2'b10, 1'b0);
      tick();
      req(1'b1, 32'h0000_0500, 32'hFFFF_FFFF, 2'b00, 1'b0);
      for (int i = 0; i < 4; i++) begin
         chk("dly_cyc", {30'b0, cyc_o, stb_o}, 32'd3);
         chk("dly_adr", adr_o, 32'h0000_0300);
         chk("dly_sel", {28'b0, sel_o}, 32'hF);
         chk("dly_dat", dat_o, 32'h1234_5678);
         chk("dly_nordy", {30'b0, req_ready_o, rsp_valid_o}, 32'd0);
         if (i == 3) ack_i = 1;
         tick();
      end
      req_valid_i = 0; ack_i = 0;
      chk("dly_rsp", {29'b0, cyc_o, rsp_valid_o, rsp_err_o}, 32'd2);
      tick();

`ifdef LSU_TIMEOUT_EN
      // No ack: watchdog fires after 4 bus cycles.
      req(1'b0, 32'h0000_0403, 32'h0, 2'b00, 1'b0);
      tick(); req_valid_i = 0;
      for (int i = 0; i < 4; i++) begin
         chk("to_cyc", {31'b0, cyc_o}, 32'd1);
         tick();
      end
      chk("to_drop", {31'b0, cyc_o}, 32'd0);
      chk("to_err", {30'b0, rsp_valid_o, rsp_err_o}, 32'd3);
      chk("to_rdata", rsp_rdata_o, 32'd0);
      tick();
`else
      // No watchdog: bus cycle holds until the slave finally acks.
      req(1'b0, 32'h0000_0403, 32'h0, 2'b00, 1'b0);
      tick(); req_valid_i = 0;
      for (int i = 0; i < 10; i++) begin
         chk("wait_cyc", {31'b0, cyc_o}, 32'd1);
         tick();
      end
      ack_i = 1;
      tick(); ack_i = 0; dat_i = 32'h80AA_BBCC;
      tick(); dat_i = 32'h0;
      chk("wait_rsp", {30'b0, rsp_valid_o, rsp_err_o}, 32'd2);
      chk("wait_lb", rsp_rdata_o, 32'hFFFF_FF80);
      tick();
`endif

      // Reset during BUS.
      req(1'b0, 32'h0000_0600, 32'h0, 2'b10, 1'b0);
      tick(); req_valid_i = 0;
      chk("rb_cyc", {31'b0, cyc_o}, 32'd1);
      rst_i = 1;
      tick();
      chk("rb_drop", {30'b0, cyc_o, stb_o}, 32'd0);
      chk("rb_ready", {30'b0, req_ready_o, rsp_valid_o}, 32'd2);
      rst_i = 0; ack_i = 1;
      for (int i = 0; i < 3; i++) begin
         tick(); ack_i = 0;
         chk("rb_norsp", {29'b0, rsp_valid_o, cyc_o, req_ready_o}, 32'd1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lsu_wb_bridge.md
LSU_WB_BRIDGE -- requirements
Module: lsu_wb_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, bus watchdog limit in cycles (used only with LSU_TIMEOUT_EN).
REQ-002 SHALL have ports, clock and reset first:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  1  core request valid.
- req_ready_o  out  1  bridge can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data, right-aligned.
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned_i  in  1  load zero-extends when 1.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_rdata_o  out  32  extended load data.
- rsp_err_o  out  1  misaligned, illegal size or timeout.
- cyc_o, stb_o  out  1 each  Wishbone cycle/strobe.
- we_o  out  1  Wishbone write enable.
- adr_o  out  32  Wishbone address.
- sel_o  out  4  Wishbone byte selects.
- dat_o  out  32  Wishbone write data.
- dat_i  in  32  Wishbone read data, valid one cycle after ack_i.
- ack_i  in  1  Wishbone acknowledge.

Function
REQ-003 SHALL implement FSM states IDLE, BUS, RDATA, RESP; req_ready_o = (state == IDLE).
REQ-004 SHALL, on accept (req_valid_i & req_ready_o) at cycle T, register we, addr, size, unsigned flag and wdata.
REQ-005 SHALL detect errors at accept: size 11, half with addr[0] = 1, or word with addr[1:0] != 0; these go IDLE -> RESP with rsp_err_o = 1 at T+1 and issue no bus cycle.
REQ-006 SHALL, for legal requests, enter BUS at T+1 and hold cyc_o = stb_o = 1 with stable adr_o, we_o, sel_o, dat_o until ack_i = 1.
REQ-007 SHALL drive adr_o = {addr[31:2], 2'b00}; sel_o = 0001<<addr[1:0] for byte, 0011<<{addr[1],1'b0} for half, 1111 for word.
REQ-008 SHALL replicate store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged.
REQ-009 SHALL, on ack_i in BUS: store -> RESP; load -> RDATA. cyc_o and stb_o drop the next cycle.
REQ-010 SHALL, in RDATA, capture dat_i shifted right by addr[1:0]*8, sign- or zero-extended per size and unsigned flag, then go to RESP.
REQ-011 SHALL assert rsp_valid_o for exactly one cycle in RESP, then return to IDLE; a new request may be accepted the following cycle.
- Latency with a zero-wait slave: store T+2, load T+3.
REQ-012 SHALL hold rsp_rdata_o at 0 for stores and errors, and keep it stable between responses.
REQ-013 SHALL ignore ack_i outside BUS and req_valid_i outside IDLE.

Reset
REQ-014 SHALL, when rst_i = 1 at a clock edge, enter IDLE and clear all outputs to 0 except req_ready_o, which becomes 1 after reset.
REQ-015 SHALL, if reset occurs mid-transaction, drop cyc_o/stb_o at that edge and produce no response.

Configuration
REQ-016 SHALL, with LSU_TIMEOUT_EN defined, count cycles in BUS; after TIMEOUT cycles without ack_i, drop cyc_o/stb_o and go to RESP with rsp_err_o = 1.
REQ-017 SHALL, without LSU_TIMEOUT_EN, have no counter and wait in BUS indefinitely.

Structure
REQ-018 SHALL place the size encoding enum, the FSM state enum and the sel/replicate/extract functions in package lsu_pkg.
REQ-019 SHALL use one combinational sub-module, lsu_align, for sel_o generation, write replication and read extraction.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Store byte 0xA5 to addr 0x102: sel_o = 0100, dat_o = 0xA5A5A5A5, rsp_valid_o at T+2, rsp_err_o = 0.
- Load half signed from 0x202 with memory word 0x8001_1234: rsp_rdata_o = 0xFFFF8001 at T+3; with unsigned = 1, rsp_rdata_o = 0x00008001.
- Load word from 0x101: no cyc_o, rsp_valid_o and rsp_err_o = 1 at T+1.
- Slave delays ack_i by 3 cycles: cyc_o, stb_o, adr_o and sel_o stay stable for 4 cycles; response follows the ack.
- With LSU_TIMEOUT_EN, TIMEOUT = 4 and no ack: cyc_o drops after 4 cycles, then rsp_err_o = 1.
- rst_i asserted in BUS: cyc_o = 0 at the next edge, no rsp_valid_o, req_ready_o = 1 afterwards.
